// File: rtl/io_port_ctrl_if.sv
// Processor-side bundle of the I/O port controller: decoder strobes, register
// data, captured switch value, stall and the LED port.
interface io_port_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              read_in;
  logic              write_out;
  logic [DATA_W-1:0] reg_data;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic [DATA_W-1:0] leds;
  logic              out_valid;

  modport master (
    output read_in,
    output write_out,
    output reg_data,
    input  in_data,
    input  stall,
    input  leds,
    input  out_valid
  );

  modport slave (
    input  read_in,
    input  write_out,
    input  reg_data,
    output in_data,
    output stall,
    output leds,
    output out_valid
  );
endinterface

// File: rtl/io_port_ctrl.sv
// Executes STIN/LOUT side effects: synchronises and debounces the board inputs,
// stalls the processor until an enter press on STIN, and drives the LED register on LOUT.
module io_port_ctrl #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_enter,
  io_port_ctrl_if.slave     bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    CAPTURED,
    WAIT_RELEASE
  } state_t;

  state_t            state;
  logic [SYNC_STAGES-1:0] enter_sync;
  logic [DATA_W-1:0] sw_sync [SYNC_STAGES];
  logic              enter_s;
  logic [DATA_W-1:0] sw_s;
  logic [CNT_W-1:0]  db_cnt;
  logic              db_level;
  logic              db_flip;
  logic              press;
  logic [DATA_W-1:0] in_data_q;
  logic [DATA_W-1:0] leds_q;
  logic              out_valid_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      enter_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i] <= '0;
      end
    end else begin
      enter_sync <= {enter_sync[SYNC_STAGES-2:0], sw_enter};
      sw_sync[0] <= sw_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i] <= sw_sync[i-1];
      end
    end
  end

  assign enter_s = enter_sync[SYNC_STAGES-1];
  assign sw_s    = sw_sync[SYNC_STAGES-1];

  // press is taken from the flip condition itself so the FSM sees it on the
  // same edge the debounced level changes, keeping latency at SYNC+DEBOUNCE.
  assign db_flip = (enter_s != db_level) && (db_cnt == CNT_MAX);
  assign press   = db_flip && enter_s;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (enter_s == db_level) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      db_level <= enter_s;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      in_data_q   <= '0;
      leds_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.write_out && !bus.read_in) begin
        leds_q      <= bus.reg_data;
        out_valid_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.read_in) begin
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!bus.read_in) begin
            state <= IDLE;
          end else if (press) begin
            in_data_q <= sw_s;
            state     <= CAPTURED;
          end
        end
        CAPTURED: begin
          state <= db_level ? WAIT_RELEASE : IDLE;
        end
        WAIT_RELEASE: begin
          if (!db_level) begin
            state <= bus.read_in ? WAIT_PRESS : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall     = n_reset && bus.read_in && (state != CAPTURED);
  assign bus.in_data   = in_data_q;
  assign bus.leds      = leds_q;
  assign bus.out_valid = out_valid_q;

  // The decoder must never issue STIN and LOUT together; STIN wins in hardware.
  assert property (@(posedge clk) disable iff (!n_reset) !(bus.read_in && bus.write_out));

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: stimulus queues expected LED and capture values,
// a negedge monitor pops and compares them whenever the DUT presents a result.
module tb_io_port_ctrl;

  localparam int DATA_W = 8;

  logic              clk;
  logic              n_reset;
  logic [DATA_W-1:0] sw_data;
  logic              sw_enter;

  int compared;
  int mismatched;

  logic [DATA_W-1:0] led_q [$];
  logic [DATA_W-1:0] cap_q [$];

  io_port_ctrl_if #(.DATA_W(DATA_W)) bus ();

  io_port_ctrl #(
    .DATA_W(DATA_W),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .sw_data(sw_data),
    .sw_enter(sw_enter),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds read_in high and counts stalled cycles until the capture cycle;
  // sw_enter falls at fall_at and rises at rise_at (negative = untouched).
  task automatic apply_stimulus(input int fall_at, input int rise_at, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    bus.read_in = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c == fall_at) sw_enter = 1'b0;
      if (c == rise_at) sw_enter = 1'b1;
      @(negedge clk);
      if (bus.stall) cycles++;
      else done = 1'b1;
      if (!done) tick();
    end
  endtask

  // Monitor: compares every LED update and every STIN capture against the queues.
  always @(negedge clk) begin
    if (n_reset) begin
      if (bus.out_valid) begin
        if (led_q.size() == 0) begin
          check_output("unexpected_led_update", 32'(bus.leds), 32'hFFFF_FFFF);
        end else begin
          check_output("leds", 32'(bus.leds), 32'(led_q.pop_front()));
        end
      end
      if (bus.read_in && !bus.stall) begin
        if (cap_q.size() == 0) begin
          check_output("unexpected_capture", 32'(bus.in_data), 32'hFFFF_FFFF);
        end else begin
          check_output("in_data", 32'(bus.in_data), 32'(cap_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int stall_low;
    compared      = 0;
    mismatched    = 0;
    n_reset       = 1'b0;
    sw_enter      = 1'b1;
    sw_data       = 8'h77;
    bus.read_in   = 1'b0;
    bus.write_out = 1'b0;
    bus.reg_data  = '0;

    // Reset state and button held through release while idle
    #2;
    check_output("rst_leds", 32'(bus.leds), 32'h0);
    check_output("rst_in_data", 32'(bus.in_data), 32'h0);
    check_output("rst_stall", 32'(bus.stall), 32'h0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
    repeat (2) @(posedge clk);
    #3 n_reset = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check_output("idle_held_stall", 32'(bus.stall), 32'h0);
    check_output("idle_held_in_data", 32'(bus.in_data), 32'h0);
    check_output("idle_held_out_valid", 32'(bus.out_valid), 32'h0);
    tick();
    sw_enter = 1'b0;
    repeat (8) tick();

    // Back-to-back LOUTs
    led_q.push_back(8'hA5);
    bus.write_out = 1'b1;
    bus.reg_data  = 8'hA5;
    tick();
    led_q.push_back(8'h5A);
    bus.reg_data  = 8'h5A;
    tick();
    bus.write_out = 1'b0;
    bus.reg_data  = 8'hFF;
    repeat (2) tick();
    @(negedge clk);
    check_output("leds_hold", 32'(bus.leds), 32'h5A);
    check_output("out_valid_idle", 32'(bus.out_valid), 32'h0);
    tick();

    // STIN with a press ten cycles in
    sw_data = 8'h3C;
    cap_q.push_back(8'h3C);
    apply_stimulus(-1, 10, cycles);
    check_output("stin1_stall_cycles", 32'(cycles), 32'd16);
    tick();
    @(negedge clk);
    check_output("stin1_single_free_cycle", 32'(bus.stall), 32'h1);
    tick();
    bus.read_in = 1'b0;
    repeat (2) tick();

    // Second STIN while the button is still held: needs release then a new press
    sw_data = 8'hC3;
    cap_q.push_back(8'hC3);
    apply_stimulus(3, 12, cycles);
    check_output("stin2_stall_cycles", 32'(cycles), 32'd18);
    tick();
    bus.read_in = 1'b0;
    sw_enter    = 1'b0;
    repeat (10) tick();

    led_q.push_back(8'h0F);
    bus.write_out = 1'b1;
    bus.reg_data  = 8'h0F;
    tick();
    bus.write_out = 1'b0;
    tick();

    // Bouncing button while waiting for a press
    sw_data     = 8'h99;
    bus.read_in = 1'b1;
    stall_low   = 0;
    for (int c = 0; c < 24; c++) begin
      logic [4:0] cv;
      cv = 5'(c);
      sw_enter = (c < 20) ? cv[1] : 1'b0;
      @(negedge clk);
      if (!bus.stall) stall_low++;
      tick();
    end
    check_output("bounce_stall_low_cycles", 32'(stall_low), 32'd0);
    check_output("bounce_in_data", 32'(bus.in_data), 32'hC3);

    // Reset mid-WAIT_PRESS
    #2 n_reset = 1'b0;
    #1;
    check_output("midrst_stall", 32'(bus.stall), 32'h0);
    check_output("midrst_leds", 32'(bus.leds), 32'h0);
    check_output("midrst_in_data", 32'(bus.in_data), 32'h0);
    bus.read_in = 1'b0;
    repeat (2) @(posedge clk);
    #3 n_reset = 1'b1;
    tick();
    sw_enter = 1'b1;
    repeat (10) tick();
    sw_enter = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check_output("postrst_stall", 32'(bus.stall), 32'h0);
    check_output("postrst_in_data", 32'(bus.in_data), 32'h0);
    check_output("postrst_leds", 32'(bus.leds), 32'h0);
    tick();

    sw_data = 8'h81;
    cap_q.push_back(8'h81);
    apply_stimulus(-1, 2, cycles);
    check_output("stin3_stall_cycles", 32'(cycles), 32'd8);
    tick();
    bus.read_in = 1'b0;
    sw_enter    = 1'b0;
    repeat (10) tick();

    check_output("led_queue_drained", 32'(led_q.size()), 32'd0);
    check_output("cap_queue_drained", 32'(cap_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
